store_unit: RTL and testbench

Write-side counterpart of the load path: takes a store request (address, data, size) from the execute stage and performs one AHB-Lite write transfer to data memory. It places data on the correct byte lanes, generates the byte write mask, sequences the address and data phases with `ahb_ready_in` wait states, and holds the pipeline busy until the transfer completes. It sits beside `load_unit` on the same data-memory port.

---
 rtl/riscv_bus_pkg.sv | 28 ++
 rtl/store_lane_align.sv | 50 +++++
 rtl/store_unit.sv | 110 +++++++++++
 tb/tb_store_unit.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/riscv_bus_pkg.sv
// Shared AHB-Lite / store-path encodings used by the data-memory port units.
package riscv_bus_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_NONSEQ = 2'b10
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } st_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } st_state_e;

endpackage

// File: rtl/store_lane_align.sv
// Combinational store formatter: replicates data across byte lanes and derives
// the byte mask, HSIZE, the naturally aligned address and a misalignment flag.
module store_lane_align
  import riscv_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DATA_W-1:0]            data,
  input  st_size_e                     size,
  output logic [ADDR_W-1:0]            addr_al,
  output logic [DATA_W/8-1:0][7:0]     lane_data,
  output logic [DATA_W/8-1:0]          mask,
  output hsize_e                       hsize,
  output logic                         misaligned
);
  localparam int NUM_LANES = DATA_W / 8;

  logic is_byte, is_half;
  assign is_byte = (size == SZ_BYTE);
  assign is_half = (size == SZ_HALF);

  // Byte replicates lane 0, half replicates lanes 1:0, word/reserved passes through.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_data[i] = is_byte ? data[7:0] :
                          is_half ? data[8*(i%2) +: 8] :
                                    data[8*i +: 8];
  end

  always_comb begin
    addr_al    = addr;
    misaligned = 1'b0;
    hsize      = HSIZE_WORD;
    mask       = '1;
    if (is_byte) begin
      hsize = HSIZE_BYTE;
      mask  = NUM_LANES'(1) << addr[1:0];
    end else if (is_half) begin
      misaligned = addr[0];
      addr_al[0] = 1'b0;
      hsize      = HSIZE_HALF;
      mask       = NUM_LANES'(3) << {addr[1], 1'b0};
    end else begin
      misaligned   = (addr[1:0] != 2'b00);
      addr_al[1:0] = 2'b00;
    end
  end

endmodule

// File: rtl/store_unit.sv
// Single-beat AHB-Lite write engine for the store path (IDLE -> ADDR -> DATA).
// STORE_MISALIGN_TRAP_EN: misaligned requests pulse st_misaligned_out instead of being forced aligned.
module store_unit
  import riscv_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                st_req_in,
  input  logic [ADDR_W-1:0]   st_addr_in,
  input  logic [DATA_W-1:0]   st_data_in,
  input  logic [1:0]          st_size_in,
  input  logic                ahb_ready_in,
  input  logic                ahb_resp_in,
  output logic [1:0]          ahb_htrans_out,
  output logic                ahb_hwrite_out,
  output logic [2:0]          ahb_hsize_out,
  output logic [ADDR_W-1:0]   dmaddr_out,
  output logic [DATA_W-1:0]   dmdata_out,
  output logic [DATA_W/8-1:0] dmwr_mask_out,
  output logic                busy_out,
  output logic                st_done_out,
  output logic                st_fault_out,
  output logic                st_misaligned_out
);
`ifdef STORE_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  st_state_e                 state_q, state_d;
  logic [ADDR_W-1:0]         al_addr;
  logic [DATA_W/8-1:0][7:0]  al_data;
  logic [DATA_W/8-1:0]       al_mask;
  hsize_e                    al_hsize;
  logic                      al_misaligned;

  store_lane_align #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_align (
    .addr       (st_addr_in),
    .data       (st_data_in),
    .size       (st_size_e'(st_size_in)),
    .addr_al    (al_addr),
    .lane_data  (al_data),
    .mask       (al_mask),
    .hsize      (al_hsize),
    .misaligned (al_misaligned)
  );

  logic idle_req, trap, start;
  assign idle_req = (state_q == ST_IDLE) && st_req_in;
  assign trap     = idle_req && al_misaligned && TRAP_EN;
  assign start    = idle_req && !trap;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)        state_d = ST_ADDR;
      ST_ADDR: if (ahb_ready_in) state_d = ST_DATA;
      ST_DATA: if (ahb_ready_in) state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so every port comes straight off a flop.
  htrans_e             htrans_d;
  logic                hwrite_d, busy_d, done_d, fault_d;
  logic [DATA_W/8-1:0] mask_d;
  always_comb begin
    htrans_d = (state_d == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    hwrite_d = (state_d == ST_ADDR);
    busy_d   = (state_d != ST_IDLE);
    mask_d   = (state_d == ST_IDLE) ? '0 : (start ? al_mask : dmwr_mask_out);
    done_d   = (state_q == ST_DATA) && ahb_ready_in;
    fault_d  = done_d && ahb_resp_in;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q           <= ST_IDLE;
      ahb_htrans_out    <= HTRANS_IDLE;
      ahb_hwrite_out    <= 1'b0;
      ahb_hsize_out     <= 3'b000;
      dmaddr_out        <= '0;
      dmdata_out        <= '0;
      dmwr_mask_out     <= '0;
      busy_out          <= 1'b0;
      st_done_out       <= 1'b0;
      st_fault_out      <= 1'b0;
      st_misaligned_out <= 1'b0;
    end else begin
      state_q           <= state_d;
      ahb_htrans_out    <= htrans_d;
      ahb_hwrite_out    <= hwrite_d;
      dmwr_mask_out     <= mask_d;
      busy_out          <= busy_d;
      st_done_out       <= done_d;
      st_fault_out      <= fault_d;
      st_misaligned_out <= trap;
      if (start) begin
        dmaddr_out    <= al_addr;
        dmdata_out    <= al_data;
        ahb_hsize_out <= al_hsize;
      end
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Randomized self-checking bench for store_unit against a behavioural lane/timing model.
module tb_store_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        st_req;
  logic [31:0] st_addr, st_data;
  logic [1:0]  st_size;
  logic        ready, resp;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] haddr, hwdata;
  logic [3:0]  mask;
  logic        busy, done, fault, mis;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  store_unit dut (
    .clk_in(clk), .rst_in(rst), .st_req_in(st_req), .st_addr_in(st_addr),
    .st_data_in(st_data), .st_size_in(st_size), .ahb_ready_in(ready), .ahb_resp_in(resp),
    .ahb_htrans_out(htrans), .ahb_hwrite_out(hwrite), .ahb_hsize_out(hsize),
    .dmaddr_out(haddr), .dmdata_out(hwdata), .dmwr_mask_out(mask), .busy_out(busy),
    .st_done_out(done), .st_fault_out(fault), .st_misaligned_out(mis)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  // Reference: what the bus should see for a given request.
  task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                       output logic [31:0] ea, output logic [31:0] ed, output logic [3:0] em,
                       output logic [2:0] es, output bit misal);
    case (sz)
      2'd0: begin
        misal = 0; ea = a; ed = {24'd0, d[7:0]} * 32'h0101_0101;
        em = 4'(32'd1 << (a % 4)); es = 3'd0;
      end
      2'd1: begin
        misal = (a % 2) != 0; ea = a - (a % 2); ed = {16'd0, d[15:0]} * 32'h0001_0001;
        em = 4'(32'd3 << (ea % 4)); es = 3'd1;
      end
      default: begin
        misal = (a % 4) != 0; ea = a - (a % 4); ed = d; em = 4'hF; es = 3'd2;
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Entered 1 time unit after an edge with the DUT idle; returns in the cycle after completion.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                          input int na, input int nd, input logic r);
    logic [31:0] ea, ed;
    logic [3:0]  em;
    logic [2:0]  es;
    bit          misal;
    bit          trap_en;
`ifdef STORE_MISALIGN_TRAP_EN
    trap_en = 1;
`else
    trap_en = 0;
`endif
    model(a, d, sz, ea, ed, em, es, misal);
    st_req = 1; st_addr = a; st_data = d; st_size = sz; ready = 1'($urandom); resp = 0;
    tick();
    st_req = 0; st_addr = $urandom; st_data = $urandom; st_size = 2'($urandom);
    if (misal && trap_en) begin
      chk("trap_mis", 32'(mis), 1);
      chk("trap_htrans", 32'(htrans), 0);
      chk("trap_busy", 32'(busy), 0);
      chk("trap_mask", 32'(mask), 0);
      return;
    end
    for (int i = 0; i <= na; i++) begin
      ready = (i == na); resp = 1'($urandom);
      chk("a_htrans", 32'(htrans), 2);
      chk("a_hwrite", 32'(hwrite), 1);
      chk("a_haddr", haddr, ea);
      chk("a_hsize", 32'(hsize), 32'(es));
      chk("a_mask", 32'(mask), 32'(em));
      chk("a_busy", 32'(busy), 1);
      chk("a_done", 32'(done), 0);
      chk("a_mis", 32'(mis), 0);
      tick();
    end
    for (int i = 0; i <= nd; i++) begin
      ready = (i == nd); resp = (i == nd) ? r : 1'($urandom);
      chk("d_htrans", 32'(htrans), 0);
      chk("d_hwdata", hwdata, ed);
      chk("d_mask", 32'(mask), 32'(em));
      chk("d_busy", 32'(busy), 1);
      chk("d_done", 32'(done), 0);
      tick();
    end
    ready = 1'($urandom); resp = 1'($urandom);
    chk("c_done", 32'(done), 1);
    chk("c_fault", 32'(fault), 32'(r));
    chk("c_busy", 32'(busy), 0);
    chk("c_mask", 32'(mask), 0);
    chk("c_htrans", 32'(htrans), 0);
  endtask

  initial begin
    rst = 1; st_req = 0; st_addr = 0; st_data = 0; st_size = 0; ready = 1; resp = 0;
    tick(); tick();
    rst = 0;
    chk("rst_htrans", 32'(htrans), 0);
    chk("rst_hwrite", 32'(hwrite), 0);
    chk("rst_hsize", 32'(hsize), 0);
    chk("rst_haddr", haddr, 0);
    chk("rst_hwdata", hwdata, 0);
    chk("rst_mask", 32'(mask), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flags", {29'd0, done, fault, mis}, 0);
    tick();

    do_store(32'h1000, 32'hDEAD_BEEF, 2'd2, 0, 0, 0);
    do_store(32'h2003, 32'h0000_00A5, 2'd0, 0, 0, 0);
    do_store(32'h2002, 32'h0000_1234, 2'd1, 2, 1, 0);
    do_store(32'h1000, 32'h0BAD_F00D, 2'd2, 0, 0, 1);
    do_store(32'h3002, 32'h5555_AAAA, 2'd2, 0, 0, 0);
    do_store(32'h4001, 32'hCAFE_0042, 2'd1, 1, 0, 0);
    do_store(32'h4007, 32'h1111_2222, 2'd3, 0, 2, 1);
    tick();

    // Reset while stalled in DATA: transfer abandoned with no completion pulse.
    st_req = 1; st_addr = 32'h5000; st_data = 32'h7777_7777; st_size = 2'd2; ready = 1;
    tick();
    st_req = 0; ready = 1;
    tick();
    ready = 0; rst = 1;
    tick();
    rst = 0; ready = 1;
    chk("mr_htrans", 32'(htrans), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_done", 32'(done), 0);
    chk("mr_fault", 32'(fault), 0);
    tick();
    chk("mr_done2", 32'(done), 0);
    chk("mr_busy2", 32'(busy), 0);

    for (int k = 0; k < 60; k++)
      do_store($urandom, $urandom, 2'($urandom_range(0, 3)),
               $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
